// File: rtl/siphash_pkg.sv
// Shared encodings for the SipHash message packer: FSM states and word geometry.
package siphash_pkg;

    localparam int WORD_BYTES = 8;
    localparam int LEN_LANE   = 7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_COMP,
        S_WAIT_C,
        S_TAIL,
        S_WAIT_T,
        S_FIN,
        S_WAIT_F
    } state_t;

endpackage

// File: rtl/siphash_word_asm.sv
// Little-endian byte-lane packer with a running message length (mod 256)
// and the SipHash tail word carrying that length in the top lane.
module siphash_word_asm
    import siphash_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clr_all,
    input  logic        clr_word,
    input  logic        wr,
    input  logic [7:0]  data,
    output logic        word_full,
    output logic [63:0] word_reg,
    output logic [63:0] tail_word
);

    logic [2:0] idx;
    logic [7:0] len;
    logic [5:0] lane_lsb;

    assign lane_lsb = {idx, 3'b000};

    always_ff @(posedge clk) begin
        if (reset || clr_all) begin
            word_reg <= 64'd0;
            idx      <= 3'd0;
            len      <= 8'd0;
        end else if (clr_word) begin
            word_reg <= 64'd0;
            idx      <= 3'd0;
        end else if (wr) begin
            word_reg[lane_lsb +: 8] <= data;
            idx                     <= idx + 3'd1;
            len                     <= len + 8'd1;
        end
    end

    // Asserted in the same cycle the top lane is being written.
    assign word_full = wr && (idx == 3'(WORD_BYTES - 1));
    assign tail_word = {len, word_reg[8*LEN_LANE-1:0]};

endmodule

// File: rtl/siphash_msg_packer.sv
// Byte-stream to 64-bit word feeder for siphash_core: packs message words,
// appends the length tail word and sequences initalize/compress/finalize.
module siphash_msg_packer
    import siphash_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    input  logic        in_empty,
    input  logic        core_ready,
    output logic        core_initalize,
    output logic        core_compress,
    output logic        core_finalize,
    output logic [63:0] core_nonce,
    output logic        busy,
    output logic        done
);

    state_t      state, state_nxt;
    logic        tail_pend, tail_pend_nxt;
    logic        first_wait;
    logic        init_nxt, done_nxt;
    logic        clr_all, clr_word;
    logic        beat, wr, word_full;
    logic [63:0] word_reg, tail_word;

    assign beat = in_valid && (state == S_FILL);
    assign wr   = beat && !in_empty;

    siphash_word_asm u_asm (
        .clk       (clk),
        .reset     (reset),
        .clr_all   (clr_all),
        .clr_word  (clr_word),
        .wr        (wr),
        .data      (in_data),
        .word_full (word_full),
        .word_reg  (word_reg),
        .tail_word (tail_word)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_IDLE;
            tail_pend      <= 1'b0;
            first_wait     <= 1'b0;
            core_initalize <= 1'b0;
            done           <= 1'b0;
        end else begin
            state          <= state_nxt;
            tail_pend      <= tail_pend_nxt;
            // The core's ready lags a strobe by one cycle, so skip it once.
            first_wait     <= (state == S_COMP) || (state == S_TAIL) || (state == S_FIN);
            core_initalize <= init_nxt;
            done           <= done_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        tail_pend_nxt = tail_pend;
        init_nxt      = 1'b0;
        done_nxt      = 1'b0;
        clr_all       = 1'b0;
        clr_word      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start && core_ready) begin
                    init_nxt      = 1'b1;
                    clr_all       = 1'b1;
                    tail_pend_nxt = 1'b0;
                    state_nxt     = S_FILL;
                end
            end
            S_FILL: begin
                if (beat) begin
                    if (word_full) begin
                        tail_pend_nxt = in_last;
                        state_nxt     = S_COMP;
                    end else if (in_last) begin
                        state_nxt = S_TAIL;
                    end
                end
            end
            S_COMP: state_nxt = S_WAIT_C;
            S_WAIT_C: begin
                if (!first_wait && core_ready) begin
                    clr_word  = 1'b1;
                    state_nxt = tail_pend ? S_TAIL : S_FILL;
                end
            end
            S_TAIL: state_nxt = S_WAIT_T;
            S_WAIT_T: begin
                if (!first_wait && core_ready) state_nxt = S_FIN;
            end
            S_FIN: state_nxt = S_WAIT_F;
            S_WAIT_F: begin
                if (!first_wait && core_ready) begin
                    done_nxt  = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign in_ready      = (state == S_FILL);
    assign busy          = (state != S_IDLE);
    assign core_compress = (state == S_COMP) || (state == S_TAIL);
    assign core_finalize = (state == S_FIN);
    assign core_nonce    = (state == S_COMP) ? word_reg  :
                           (state == S_TAIL) ? tail_word : 64'd0;

endmodule

// File: tb/tb_siphash_msg_packer.sv
// Bench for siphash_msg_packer with a cycle-level model of the core's ready.
module tb_siphash_msg_packer;

    localparam int C_ROUNDS = 2;
    localparam int D_ROUNDS = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        in_empty = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready, core_ready, core_initalize, core_compress, core_finalize;
    logic        busy, done;
    logic [63:0] core_nonce;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0, low_from = 0, ready_at = 0;
    int init_cnt = 0, viol = 0;
    logic [63:0] comp_q[$];
    int          comp_cyc[$];
    int          fin_cyc[$];
    int          done_cyc[$];
    logic [7:0]  msg[$];
    logic [63:0] exp_q[$];

    typedef struct {
        int          n;
        bit          marker;
        bit          toggle;
        int          cnt;
        logic [63:0] first;
        logic [63:0] last;
    } vec_t;

    always #5 clk = ~clk;

    siphash_msg_packer dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .in_last        (in_last),
        .in_empty       (in_empty),
        .core_ready     (core_ready),
        .core_initalize (core_initalize),
        .core_compress  (core_compress),
        .core_finalize  (core_finalize),
        .core_nonce     (core_nonce),
        .busy           (busy),
        .done           (done)
    );

    // Core ready: still 1 the cycle after a strobe, low for the rounds, then 1.
    assign core_ready = !(cyc >= low_from && cyc < ready_at);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) begin
            low_from <= 0;
            ready_at <= 0;
        end else if (core_compress) begin
            low_from <= cyc + 2;
            ready_at <= cyc + C_ROUNDS + 2;
        end else if (core_finalize) begin
            low_from <= cyc + 2;
            ready_at <= cyc + D_ROUNDS + 2;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (core_compress) begin
                comp_q.push_back(core_nonce);
                comp_cyc.push_back(cyc);
            end else if (core_nonce != 64'd0) begin
                viol++;
            end
            if (core_finalize) fin_cyc.push_back(cyc);
            if (core_initalize) init_cnt++;
            if (done) done_cyc.push_back(cyc);
            if (32'(core_compress) + 32'(core_finalize) + 32'(core_initalize) > 1) viol++;
            if (in_ready && !busy) viol++;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: whole 8-byte groups little-endian, then remainder plus length byte.
    task automatic build_model();
        int n = msg.size();
        logic [63:0] w;
        exp_q.delete();
        for (int k = 0; k < n / 8; k++) begin
            w = 64'd0;
            for (int b = 0; b < 8; b++) w[8*b +: 8] = msg[8*k + b];
            exp_q.push_back(w);
        end
        w = 64'd0;
        for (int b = 0; b < n % 8; b++) w[8*b +: 8] = msg[8*(n/8) + b];
        w[63:56] = 8'(n % 256);
        exp_q.push_back(w);
    endtask

    task automatic clear_mon();
        @(posedge clk);
        #1;
        comp_q.delete();
        comp_cyc.delete();
        fin_cyc.delete();
        done_cyc.delete();
        init_cnt = 0;
    endtask

    task automatic start_msg();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_beats(input bit marker, input bit toggle);
        int beats = msg.size() + ((marker || msg.size() == 0) ? 1 : 0);
        int i = 0;
        for (int g = 0; g < 20000 && i < beats; g++) begin
            @(negedge clk);
            in_valid = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
            if (i < msg.size()) begin
                in_data  = msg[i];
                in_empty = 1'b0;
                in_last  = (i == msg.size() - 1) && !marker;
            end else begin
                in_data  = 8'h00;
                in_empty = 1'b1;
                in_last  = 1'b1;
            end
            if (in_valid && in_ready) i++;
        end
        check("beats_accepted", 64'(i), 64'(beats));
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_empty = 1'b0;
    endtask

    task automatic wait_done();
        for (int g = 0; g < 5000 && done_cyc.size() == 0; g++) @(negedge clk);
        repeat (4) @(negedge clk);
    endtask

    task automatic run_msg(input bit marker, input bit toggle);
        clear_mon();
        start_msg();
        send_beats(marker, toggle);
        wait_done();
    endtask

    task automatic check_common(input string tag);
        check({tag, "_fin_cnt"}, 64'(fin_cyc.size()), 64'd1);
        check({tag, "_done_cnt"}, 64'(done_cyc.size()), 64'd1);
        check({tag, "_init_cnt"}, 64'(init_cnt), 64'd1);
        if (fin_cyc.size() == 1 && done_cyc.size() == 1)
            check({tag, "_done_lat"}, 64'(done_cyc[0] - fin_cyc[0]), 64'(D_ROUNDS + 3));
        if (fin_cyc.size() == 1 && comp_cyc.size() > 0)
            check({tag, "_fin_lat"}, 64'(fin_cyc[0] - comp_cyc[$]), 64'(C_ROUNDS + 3));
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vt[6];
        int   n;
        vt[0] = '{0,   1'b0, 1'b0, 1,  64'h0000000000000000, 64'h0000000000000000};
        vt[1] = '{7,   1'b0, 1'b0, 1,  64'h0706050403020100, 64'h0706050403020100};
        vt[2] = '{8,   1'b0, 1'b0, 2,  64'h0706050403020100, 64'h0800000000000000};
        vt[3] = '{15,  1'b0, 1'b1, 2,  64'h0706050403020100, 64'h0f0e0d0c0b0a0908};
        vt[4] = '{300, 1'b0, 1'b1, 38, 64'h0706050403020100, 64'h2c0000002b2a2928};
        vt[5] = '{8,   1'b1, 1'b1, 2,  64'h0706050403020100, 64'h0800000000000000};

        repeat (3) @(negedge clk);
        check("reset_ctl", {58'd0, in_ready, core_initalize, core_compress, core_finalize, busy, done}, 64'd0);
        check("reset_nonce", core_nonce, 64'd0);
        reset = 1'b0;

        for (int v = 0; v < 6; v++) begin
            msg.delete();
            for (int k = 0; k < vt[v].n; k++) msg.push_back(8'(k));
            run_msg(vt[v].marker, vt[v].toggle);
            check("vec_comp_cnt", 64'(comp_q.size()), 64'(vt[v].cnt));
            if (comp_q.size() > 0) begin
                check("vec_first_nonce", comp_q[0], vt[v].first);
                check("vec_last_nonce", comp_q[$], vt[v].last);
            end
            check_common("vec");
        end

        // 16 bytes back to back: full-rate refill, then tail straight after wait.
        msg.delete();
        for (int k = 0; k < 16; k++) msg.push_back(8'(k));
        run_msg(1'b0, 1'b0);
        check("b16_comp_cnt", 64'(comp_q.size()), 64'd3);
        if (comp_cyc.size() == 3) begin
            check("b16_refill_gap", 64'(comp_cyc[1] - comp_cyc[0]), 64'(C_ROUNDS + 11));
            check("b16_tail_gap", 64'(comp_cyc[2] - comp_cyc[1]), 64'(C_ROUNDS + 3));
            check("b16_tail_nonce", comp_q[2], 64'h1000000000000000);
        end

        for (int r = 0; r < 12; r++) begin
            n = $urandom_range(0, 40);
            msg.delete();
            for (int k = 0; k < n; k++) msg.push_back(8'($urandom_range(0, 255)));
            build_model();
            run_msg(1'($urandom_range(0, 1)), 1'b1);
            check("rnd_comp_cnt", 64'(comp_q.size()), 64'(exp_q.size()));
            for (int k = 0; k < exp_q.size() && k < comp_q.size(); k++)
                check("rnd_nonce", comp_q[k], exp_q[k]);
            check_common("rnd");
        end

        // Abort in the first WAIT_C cycle.
        msg.delete();
        for (int k = 0; k < 8; k++) msg.push_back(8'(k));
        clear_mon();
        start_msg();
        send_beats(1'b0, 1'b0);
        @(negedge clk);
        check("pre_reset_busy", {63'd0, busy}, 64'd1);
        reset = 1'b1;
        @(negedge clk);
        check("abort_ctl", {58'd0, in_ready, core_initalize, core_compress, core_finalize, busy, done}, 64'd0);
        check("abort_nonce", core_nonce, 64'd0);
        reset = 1'b0;
        check("abort_comp_cnt", 64'(comp_q.size()), 64'd1);
        check("abort_no_fin", 64'(fin_cyc.size()), 64'd0);

        // Fresh empty message, with start pulsed while busy.
        msg.delete();
        clear_mon();
        start_msg();
        send_beats(1'b0, 1'b0);
        start = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b0;
        wait_done();
        check("empty_comp_cnt", 64'(comp_q.size()), 64'd1);
        if (comp_q.size() > 0) check("empty_nonce", comp_q[0], 64'h0);
        check_common("empty");
        repeat (3) @(negedge clk);
        check("idle_after", {63'd0, busy}, 64'd0);

        check("protocol_viol", 64'(viol), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
